// File: rtl/programmatore_fasce.sv
// programmatore_fasce
//   Time-band programmer for the thermostat. Takes hour/minute updates from the
//   house clock and picks the setpoint of the active band out of a small table
//   that the user interface can write.
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     en                     1 = time ticks are processed, 0 = ticks ignored
//     tick, ora, minuti      one-cycle strobe carrying a new time value
//     wr_en, wr_idx,         one-cycle table write: entry index, active bit,
//     wr_attiva, wr_ora,     band start hour/minute and band setpoint
//     wr_min, wr_temp
//     setpoint, fascia       selected setpoint and index of the selected entry
//     cambio                 one-cycle pulse when setpoint or fascia changes
//     busy                   a table scan is in progress
//     wr_err                 one-cycle pulse: last write had an out-of-range time
module programmatore_fasce #(
   parameter int                 N_FASCE      = 4,
   parameter int                 ORA_MAX      = 6,
   parameter int                 MIN_MAX      = 60,
   parameter int                 TEMP_W       = 8,
   parameter logic [TEMP_W-1:0]  TEMP_DEFAULT = TEMP_W'(36),
   localparam int                IDX_W        = $clog2(N_FASCE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              tick,
   input  logic [2:0]        ora,
   input  logic [5:0]        minuti,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              wr_attiva,
   input  logic [2:0]        wr_ora,
   input  logic [5:0]        wr_min,
   input  logic [TEMP_W-1:0] wr_temp,
   output logic [TEMP_W-1:0] setpoint,
   output logic [IDX_W-1:0]  fascia,
   output logic              cambio,
   output logic              busy,
   output logic              wr_err
);

   typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FASCE - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [8:0]        snap_q, snap_d;
   logic [8:0]        pend_time_q, pend_time_d;
   logic              pending_q, pending_d;

   logic              tbl_att_q  [N_FASCE];
   logic              tbl_att_d  [N_FASCE];
   logic [8:0]        tbl_key_q  [N_FASCE];
   logic [8:0]        tbl_key_d  [N_FASCE];
   logic [TEMP_W-1:0] tbl_temp_q [N_FASCE];
   logic [TEMP_W-1:0] tbl_temp_d [N_FASCE];

   logic              le_found_q, le_found_d;
   logic [8:0]        le_key_q, le_key_d;
   logic [IDX_W-1:0]  le_idx_q, le_idx_d;
   logic              mx_found_q, mx_found_d;
   logic [8:0]        mx_key_q, mx_key_d;
   logic [IDX_W-1:0]  mx_idx_q, mx_idx_d;

   logic [TEMP_W-1:0] setpoint_q, setpoint_d;
   logic [IDX_W-1:0]  fascia_q, fascia_d;
   logic              cambio_q, cambio_d;
   logic              wr_err_q, wr_err_d;

   logic              wr_ok, tick_ok;
   logic [8:0]        cur_key;
   logic [IDX_W-1:0]  sel_idx;
   logic [TEMP_W-1:0] sel_temp;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      pend_time_d = pend_time_q;
      pending_d   = pending_q;
      tbl_att_d   = tbl_att_q;
      tbl_key_d   = tbl_key_q;
      tbl_temp_d  = tbl_temp_q;
      le_found_d  = le_found_q;
      le_key_d    = le_key_q;
      le_idx_d    = le_idx_q;
      mx_found_d  = mx_found_q;
      mx_key_d    = mx_key_q;
      mx_idx_d    = mx_idx_q;
      setpoint_d  = setpoint_q;
      fascia_d    = fascia_q;
      cambio_d    = 1'b0;
      wr_err_d    = 1'b0;
      sel_idx     = '0;
      sel_temp    = TEMP_DEFAULT;

      wr_ok   = (32'(wr_ora) < 32'(ORA_MAX)) && (32'(wr_min) < 32'(MIN_MAX));
      tick_ok = (32'(ora) < 32'(ORA_MAX)) && (32'(minuti) < 32'(MIN_MAX));
      cur_key = tbl_key_q[idx_q];

      case (state_q)
         IDLE: begin
            if (pending_q) begin
               snap_d     = pend_time_q;
               pending_d  = 1'b0;
               idx_d      = '0;
               le_found_d = 1'b0;
               mx_found_d = 1'b0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            // Strict greater-than: on equal keys the lower index is kept.
            if (tbl_att_q[idx_q]) begin
               if (cur_key <= snap_q && (!le_found_q || cur_key > le_key_q)) begin
                  le_found_d = 1'b1;
                  le_key_d   = cur_key;
                  le_idx_d   = idx_q;
               end
               if (!mx_found_q || cur_key > mx_key_q) begin
                  mx_found_d = 1'b1;
                  mx_key_d   = cur_key;
                  mx_idx_d   = idx_q;
               end
            end
            idx_d = idx_q + 1'b1;
            // The last entry's result is folded in combinationally so the
            // outputs register on the same edge that enters UPDATE.
            if (idx_q == LAST_IDX) begin
               state_d = UPDATE;
               if (le_found_d) begin
                  sel_idx  = le_idx_d;
                  sel_temp = tbl_temp_q[le_idx_d];
               end else if (mx_found_d) begin
                  sel_idx  = mx_idx_d;
                  sel_temp = tbl_temp_q[mx_idx_d];
               end
               setpoint_d = sel_temp;
               fascia_d   = sel_idx;
               cambio_d   = (sel_temp != setpoint_q) || (sel_idx != fascia_q);
            end
         end
         UPDATE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Applied after the FSM so a new request overrides the pending clear.
      if (wr_en) begin
         if (!wr_ok) begin
            wr_err_d = 1'b1;
         end else if (32'(wr_idx) < 32'(N_FASCE)) begin
            tbl_att_d[wr_idx]  = wr_attiva;
            tbl_key_d[wr_idx]  = {wr_ora, wr_min};
            tbl_temp_d[wr_idx] = wr_temp;
            pending_d          = 1'b1;
         end
      end
      if (tick && en && tick_ok) begin
         pend_time_d = {ora, minuti};
         pending_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         pend_time_q <= '0;
         pending_q   <= 1'b0;
         for (int unsigned i = 0; i < N_FASCE; i++) begin
            tbl_att_q[i]  <= 1'b0;
            tbl_key_q[i]  <= '0;
            tbl_temp_q[i] <= '0;
         end
         le_found_q  <= 1'b0;
         le_key_q    <= '0;
         le_idx_q    <= '0;
         mx_found_q  <= 1'b0;
         mx_key_q    <= '0;
         mx_idx_q    <= '0;
         setpoint_q  <= TEMP_DEFAULT;
         fascia_q    <= '0;
         cambio_q    <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         pend_time_q <= pend_time_d;
         pending_q   <= pending_d;
         tbl_att_q   <= tbl_att_d;
         tbl_key_q   <= tbl_key_d;
         tbl_temp_q  <= tbl_temp_d;
         le_found_q  <= le_found_d;
         le_key_q    <= le_key_d;
         le_idx_q    <= le_idx_d;
         mx_found_q  <= mx_found_d;
         mx_key_q    <= mx_key_d;
         mx_idx_q    <= mx_idx_d;
         setpoint_q  <= setpoint_d;
         fascia_q    <= fascia_d;
         cambio_q    <= cambio_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign setpoint = setpoint_q;
   assign fascia   = fascia_q;
   assign cambio   = cambio_q;
   assign busy     = (state_q != IDLE);
   assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_programmatore_fasce.sv
// tb_programmatore_fasce
//   Directed bench for programmatore_fasce: band selection, wrap-around to the
//   previous cycle's last band, tick coalescing during a scan, rejected writes,
//   en gating and reset in the middle of a scan.
module tb_programmatore_fasce;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       tick;
   logic [2:0] ora;
   logic [5:0] minuti;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic       wr_attiva;
   logic [2:0] wr_ora;
   logic [5:0] wr_min;
   logic [7:0] wr_temp;
   logic [7:0] setpoint;
   logic [1:0] fascia;
   logic       cambio;
   logic       busy;
   logic       wr_err;

   int checks = 0;
   int errors = 0;

   programmatore_fasce #(
      .N_FASCE(N), .ORA_MAX(6), .MIN_MAX(60), .TEMP_W(8), .TEMP_DEFAULT(8'd36)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .tick(tick), .ora(ora), .minuti(minuti),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_attiva(wr_attiva), .wr_ora(wr_ora),
      .wr_min(wr_min), .wr_temp(wr_temp), .setpoint(setpoint), .fascia(fascia),
      .cambio(cambio), .busy(busy), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] idx, input logic att, input logic [2:0] o,
                           input logic [5:0] m, input logic [7:0] t);
      wr_en = 1'b1; wr_idx = idx; wr_attiva = att; wr_ora = o; wr_min = m; wr_temp = t;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_tick(input logic [2:0] o, input logic [5:0] m);
      tick = 1'b1; ora = o; minuti = m;
      step();
      tick = 1'b0;
   endtask

   // Waits until the block has been idle for two consecutive samples.
   task automatic wait_idle(input string tag);
      int zeros = 0;
      int cyc = 0;
      while (zeros < 2 && cyc < 60) begin
         step();
         cyc++;
         zeros = busy ? 0 : zeros + 1;
      end
      check({tag, "_idle_timeout"}, 32'(zeros >= 2), 32'd1);
   endtask

   // Tick at edge k; outputs are checked right after edge k+N+1 and k+N+2.
   task automatic tick_and_check(input string tag, input logic [2:0] o, input logic [5:0] m,
                                 input logic [7:0] exp_sp, input logic [1:0] exp_f,
                                 input logic exp_c);
      pulse_tick(o, m);
      for (int i = 0; i < N + 1; i++) begin
         step();
         if (i == 0) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      end
      check({tag, "_setpoint"}, 32'(setpoint), 32'(exp_sp));
      check({tag, "_fascia"}, 32'(fascia), 32'(exp_f));
      check({tag, "_cambio"}, 32'(cambio), 32'(exp_c));
      check({tag, "_busy_upd"}, 32'(busy), 32'd1);
      step();
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_cambio_end"}, 32'(cambio), 32'd0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #12;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int rises, cambios, zeros, cyc, highs;
      logic prev_busy;
      rst = 1'b1; en = 1'b1; tick = 1'b0; ora = '0; minuti = '0;
      wr_en = 1'b0; wr_idx = '0; wr_attiva = 1'b0; wr_ora = '0; wr_min = '0; wr_temp = '0;
      apply_reset();

      check("rst_setpoint", 32'(setpoint), 32'd36);
      check("rst_fascia", 32'(fascia), 32'd0);
      check("rst_cambio", 32'(cambio), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_err", 32'(wr_err), 32'd0);

      // 1: empty table
      tick_and_check("t1", 3'd2, 6'd15, 8'd36, 2'd0, 1'b0);

      // 2: two bands; rescan from snapshot 0:00 wraps to e1
      apply_reset();
      do_write(2'd0, 1'b1, 3'd1, 6'd0, 8'd40);
      do_write(2'd1, 1'b1, 3'd4, 6'd30, 8'd34);
      wait_idle("t2_wr");
      check("t2_wr_setpoint", 32'(setpoint), 32'd34);
      check("t2_wr_fascia", 32'(fascia), 32'd1);
      tick_and_check("t2a", 3'd2, 6'd15, 8'd40, 2'd0, 1'b1);
      tick_and_check("t2b", 3'd4, 6'd30, 8'd34, 2'd1, 1'b1);
      tick_and_check("t2c", 3'd5, 6'd59, 8'd34, 2'd1, 1'b0);

      // 3: before every band -> previous cycle's last band
      tick_and_check("t3a", 3'd2, 6'd15, 8'd40, 2'd0, 1'b1);
      tick_and_check("t3b", 3'd0, 6'd10, 8'd34, 2'd1, 1'b1);
      tick_and_check("t3c", 3'd1, 6'd0, 8'd40, 2'd0, 1'b1);

      // 4: ticks at 3:00 and 4:45 during a scan started by 1:30
      rises = 0; cambios = 0; zeros = 0; cyc = 0; prev_busy = 1'b0;
      while (zeros < 2 && cyc < 40) begin
         tick = (cyc == 0 || cyc == 2 || cyc == 3);
         ora    = (cyc == 0) ? 3'd1  : (cyc == 2) ? 3'd3 : 3'd4;
         minuti = (cyc == 0) ? 6'd30 : (cyc == 2) ? 6'd0 : 6'd45;
         step();
         tick = 1'b0;
         if (busy && !prev_busy) rises++;
         if (cambio) cambios++;
         prev_busy = busy;
         zeros = (cyc >= 4 && !busy) ? zeros + 1 : 0;
         cyc++;
      end
      check("t4_done", 32'(zeros >= 2), 32'd1);
      check("t4_scans", 32'(rises), 32'd2);
      check("t4_cambios", 32'(cambios), 32'd1);
      check("t4_cycles", 32'(cyc <= 2 * (N + 1) + 4), 32'd1);
      check("t4_setpoint", 32'(setpoint), 32'd34);
      check("t4_fascia", 32'(fascia), 32'd1);

      // 5: out-of-range writes, out-of-range tick, en=0
      do_write(2'd0, 1'b1, 3'd6, 6'd0, 8'd99);
      check("t5_err_ora", 32'(wr_err), 32'd1);
      check("t5_err_ora_busy", 32'(busy), 32'd0);
      step();
      check("t5_err_clear", 32'(wr_err), 32'd0);
      do_write(2'd1, 1'b1, 3'd0, 6'd60, 8'd99);
      check("t5_err_min", 32'(wr_err), 32'd1);
      do_write(2'd2, 1'b1, 3'd5, 6'd59, 8'd50);
      check("t5_ok_no_err", 32'(wr_err), 32'd0);
      wait_idle("t5_wr");
      check("t5_sp_after_ok", 32'(setpoint), 32'd34);
      check("t5_f_after_ok", 32'(fascia), 32'd1);
      pulse_tick(3'd7, 6'd0);
      highs = 0;
      for (int i = 0; i < N + 3; i++) begin step(); if (busy) highs++; end
      check("t5_bad_tick_busy", 32'(highs), 32'd0);
      en = 1'b0;
      pulse_tick(3'd2, 6'd15);
      highs = 0;
      for (int i = 0; i < N + 3; i++) begin step(); if (busy) highs++; end
      check("t5_en0_busy", 32'(highs), 32'd0);
      check("t5_en0_setpoint", 32'(setpoint), 32'd34);
      en = 1'b1;
      tick_and_check("t5_table", 3'd2, 6'd15, 8'd40, 2'd0, 1'b1);
      tick_and_check("t5_e2", 3'd5, 6'd59, 8'd50, 2'd2, 1'b1);

      // 6: reset in the middle of a scan
      pulse_tick(3'd0, 6'd10);
      step();
      step();
      check("t6_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_setpoint", 32'(setpoint), 32'd36);
      check("t6_fascia", 32'(fascia), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_cambio", 32'(cambio), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      tick_and_check("t6_cleared", 3'd2, 6'd15, 8'd36, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
